// File: rtl/conv_fprop1_mac_pipe_pkg.sv
// conv_fprop1 shared package: beat mode encoding, sideband
// bundle, narrowing helper and parameter legality check.
package conv_fprop1_pkg;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_MAC = 1'b1;

    typedef struct packed {
        logic vld;
        logic mac;
        logic clr;
    } side_t;

    typedef struct packed {
        logic signed [63:0] val;
        logic               ovf;
    } narrow_t;

    // Out of range is the same condition as "dropped bits are
    // not a sign extension", so ovf serves both narrowing modes.
    function automatic narrow_t sat_narrow(
        input logic signed [63:0] value,
        input int                 width
    );
        narrow_t            r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi    = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo    = -hi - 64'sd1;
        r.ovf = (value > hi) || (value < lo);
        if (value > hi)
            r.val = hi;
        else if (value < lo)
            r.val = lo;
        else
            r.val = value;
        return r;
    endfunction

    function automatic bit cfg_ok(
        input int ns,
        input int w0,
        input int w1,
        input int aw,
        input int dw,
        input int id
    );
        return (ns >= 1) && (ns <= 4) &&
               (w0 >= 2) && (w1 >= 2) &&
               (aw >= w0 + w1) &&
               (dw >= 2) && (dw <= aw) &&
               (id >= 0);
    endfunction

endpackage

// File: rtl/conv_fprop1_mac_pipe_if.sv
// Operand-in / result-out handshake bundle for
// conv_fprop1_mac_pipe.
interface conv_fprop1_mac_pipe_if #(
    parameter int W0 = 10,
    parameter int W1 = 10,
    parameter int WO = 20
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [W0-1:0] din0;
    logic signed [W1-1:0] din1;
    logic                 mac_en;
    logic                 acc_clr;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [WO-1:0] dout;
    logic                 ovf;

    modport master (
        output in_valid, din0, din1, mac_en, acc_clr,
        output out_ready,
        input  in_ready, out_valid, dout, ovf
    );

    modport slave (
        input  in_valid, din0, din1, mac_en, acc_clr,
        input  out_ready,
        output in_ready, out_valid, dout, ovf
    );
endinterface

// File: rtl/conv_fprop1_mul_pipe.sv
// Signed product pipeline: operand register followed by
// NUM_STAGE product registers, sideband travelling alongside.
module conv_fprop1_mul_pipe
    import conv_fprop1_pkg::*;
#(
    parameter int NUM_STAGE = 2,
    parameter int W0        = 10,
    parameter int W1        = 10,
    parameter int PW        = W0 + W1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_en,
    input  logic signed [W0-1:0] i_a,
    input  logic signed [W1-1:0] i_b,
    input  side_t                i_side,
    output logic signed [PW-1:0] o_prod,
    output side_t                o_side
);
    logic signed [PW-1:0] r_a;
    logic signed [PW-1:0] r_b;
    side_t                r_side0;
    logic signed [PW-1:0] r_prod [NUM_STAGE];
    side_t                r_side [NUM_STAGE];
    logic signed [PW-1:0] w_mul;

    // Both operands fit in PW bits, so the PW-bit product is exact.
    assign w_mul = r_a * r_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_side0 <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                r_prod[i] <= '0;
                r_side[i] <= '0;
            end
        end else if (i_en) begin
            r_a       <= PW'(i_a);
            r_b       <= PW'(i_b);
            r_side0   <= i_side;
            r_prod[0] <= w_mul;
            r_side[0] <= r_side0;
            for (int i = 1; i < NUM_STAGE; i++) begin
                r_prod[i] <= r_prod[i-1];
                r_side[i] <= r_side[i-1];
            end
        end
    end

    assign o_prod = r_prod[NUM_STAGE-1];
    assign o_side = r_side[NUM_STAGE-1];
endmodule

// File: rtl/conv_fprop1_mac_pipe.sv
// Pipelined signed MUL/MAC unit with valid/ready flow control,
// clock enable and wrap/saturate output narrowing.
module conv_fprop1_mac_pipe
    import conv_fprop1_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 10,
    parameter int din1_WIDTH = 10,
    parameter int ACC_WIDTH  = 24,
    parameter int dout_WIDTH = 20,
    parameter int SATURATE   = 0
) (
    input logic                  clk,
    input logic                  reset,
    input logic                  ce,
    conv_fprop1_mac_pipe_if.slave bus
);
    localparam int PW = din0_WIDTH + din1_WIDTH;

    if (!cfg_ok(NUM_STAGE, din0_WIDTH, din1_WIDTH,
                ACC_WIDTH, dout_WIDTH, ID)) begin : g_bad_cfg
        $error("conv_fprop1_mac_pipe: illegal parameters");
    end

    logic                         w_adv;
    side_t                        w_in_side;
    logic signed [PW-1:0]         w_prod;
    side_t                        w_side;
    logic signed [ACC_WIDTH-1:0]  w_pext;
    logic signed [ACC_WIDTH-1:0]  w_res;
    narrow_t                      w_nar;
    logic signed [dout_WIDTH-1:0] w_dout;
    logic                         w_unused;

    logic                         r_vld;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic signed [dout_WIDTH-1:0] r_dout;
    logic                         r_ovf;

    // Every stage moves together; a stalled output freezes all.
    assign w_adv     = ce & (~r_vld | bus.out_ready);
    assign w_in_side = {bus.in_valid, bus.mac_en, bus.acc_clr};

    conv_fprop1_mul_pipe #(
        .NUM_STAGE (NUM_STAGE),
        .W0        (din0_WIDTH),
        .W1        (din1_WIDTH),
        .PW        (PW)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_adv),
        .i_a    (bus.din0),
        .i_b    (bus.din1),
        .i_side (w_in_side),
        .o_prod (w_prod),
        .o_side (w_side)
    );

    assign w_pext = ACC_WIDTH'(w_prod);

    always_comb begin
        w_res = w_pext;
        if (w_side.mac == MODE_MAC && !w_side.clr)
            w_res = r_acc + w_pext;
    end

    assign w_nar    = sat_narrow(64'(w_res), dout_WIDTH);
    assign w_dout   = (SATURATE != 0) ? w_nar.val[dout_WIDTH-1:0]
                                      : w_res[dout_WIDTH-1:0];
    assign w_unused = ^w_nar.val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld  <= 1'b0;
            r_acc  <= '0;
            r_dout <= '0;
            r_ovf  <= 1'b0;
        end else if (w_adv) begin
            r_vld <= w_side.vld;
            if (w_side.vld) begin
                if (w_side.mac == MODE_MAC)
                    r_acc <= w_res;
                r_dout <= w_dout;
                r_ovf  <= w_nar.ovf;
            end
        end
    end

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_vld;
    assign bus.dout      = r_dout;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_conv_fprop1_mac_pipe.sv
// Bench for conv_fprop1_mac_pipe: three instances (wrap/20,
// saturate/10, wrap/10) share one stimulus stream.
module tb_conv_fprop1_mac_pipe;
    localparam int NS = 2;
    localparam int W0 = 10;
    localparam int W1 = 10;
    localparam int AW = 24;
    localparam int DW = 20;
    localparam int NW = 10;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 ce;
    logic                 in_valid;
    logic                 mac_en;
    logic                 acc_clr;
    logic                 out_ready;
    logic signed [W0-1:0] din0;
    logic signed [W1-1:0] din1;

    conv_fprop1_mac_pipe_if #(.W0(W0), .W1(W1), .WO(DW)) m_if ();
    conv_fprop1_mac_pipe_if #(.W0(W0), .W1(W1), .WO(NW)) s_if ();
    conv_fprop1_mac_pipe_if #(.W0(W0), .W1(W1), .WO(NW)) w_if ();

    assign m_if.in_valid = in_valid;  assign m_if.din0 = din0;
    assign m_if.din1 = din1;          assign m_if.mac_en = mac_en;
    assign m_if.acc_clr = acc_clr;    assign m_if.out_ready = out_ready;
    assign s_if.in_valid = in_valid;  assign s_if.din0 = din0;
    assign s_if.din1 = din1;          assign s_if.mac_en = mac_en;
    assign s_if.acc_clr = acc_clr;    assign s_if.out_ready = out_ready;
    assign w_if.in_valid = in_valid;  assign w_if.din0 = din0;
    assign w_if.din1 = din1;          assign w_if.mac_en = mac_en;
    assign w_if.acc_clr = acc_clr;    assign w_if.out_ready = out_ready;

    conv_fprop1_mac_pipe #(
        .NUM_STAGE(NS), .din0_WIDTH(W0), .din1_WIDTH(W1),
        .ACC_WIDTH(AW), .dout_WIDTH(DW), .SATURATE(0)
    ) u_dut (.clk(clk), .reset(reset), .ce(ce), .bus(m_if.slave));

    conv_fprop1_mac_pipe #(
        .NUM_STAGE(NS), .din0_WIDTH(W0), .din1_WIDTH(W1),
        .ACC_WIDTH(AW), .dout_WIDTH(NW), .SATURATE(1)
    ) u_sat (.clk(clk), .reset(reset), .ce(ce), .bus(s_if.slave));

    conv_fprop1_mac_pipe #(
        .NUM_STAGE(NS), .din0_WIDTH(W0), .din1_WIDTH(W1),
        .ACC_WIDTH(AW), .dout_WIDTH(NW), .SATURATE(0)
    ) u_wrp (.clk(clk), .reset(reset), .ce(ce), .bus(w_if.slave));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag,
                         input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference arithmetic: two's-complement wrap and clamp.
    function automatic longint sx(input longint v, input int w);
        longint m;
        longint r;
        m = longint'(1) <<< w;
        r = v & (m - 1);
        if (r >= (m >>> 1)) r = r - m;
        return r;
    endfunction

    function automatic longint clampw(input longint v, input int w);
        longint hi;
        hi = (longint'(1) <<< (w - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    typedef struct {
        longint m;
        longint s;
        longint w;
        logic   mo;
        logic   so;
        logic   wo;
    } obs_t;

    longint expq[$];
    obs_t   obs[$];
    longint macc;

    task automatic model_push();
        longint p;
        p = longint'(din0) * longint'(din1);
        if (!mac_en) begin
            expq.push_back(p);
        end else begin
            macc = acc_clr ? p : sx(macc + p, AW);
            expq.push_back(macc);
        end
    endtask

    task automatic pop_check();
        longint e;
        obs_t   o;
        if (expq.size() == 0) begin
            check("extra_result", 1, 0);
            return;
        end
        e    = expq.pop_front();
        o.m  = m_if.dout;  o.mo = m_if.ovf;
        o.s  = s_if.dout;  o.so = s_if.ovf;
        o.w  = w_if.dout;  o.wo = w_if.ovf;
        check("dout_wrap20", o.m, sx(e, DW));
        check("ovf_wrap20", o.mo, e != clampw(e, DW));
        check("dout_sat10", o.s, clampw(e, NW));
        check("ovf_sat10", o.so, e != clampw(e, NW));
        check("dout_wrap10", o.w, sx(e, NW));
        check("ovf_wrap10", o.wo, e != clampw(e, NW));
        obs.push_back(o);
    endtask

    // A transfer on either side happens only on an advancing edge.
    always @(negedge clk) begin
        if (!reset && ce) begin
            if (m_if.out_valid && out_ready) pop_check();
            if (in_valid && m_if.in_ready) model_push();
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int b,
                        input logic mac, input logic clr);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        din0 = W0'(a);  din1 = W1'(b);
        mac_en = mac;   acc_clr = clr;
        in_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = m_if.in_ready;
            step();
            n++;
        end
        check("accept", ok, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (expq.size() != 0 && n < 100) begin
            step();
            n++;
        end
        step(2);
        check("drain", expq.size(), 0);
    endtask

    task automatic check4(input string tag, input longint a,
                          input longint b, input longint c,
                          input longint d);
        check({tag, "_n"}, obs.size(), 4);
        if (obs.size() == 4) begin
            check({tag, "0"}, obs[0].m, a);
            check({tag, "1"}, obs[1].m, b);
            check({tag, "2"}, obs[2].m, c);
            check({tag, "3"}, obs[3].m, d);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        reset = 1'b1;  ce = 1'b1;   in_valid = 1'b0;
        mac_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        din0 = '0;     din1 = '0;   macc = 0;
        step(3);
        check("rst_out_valid", m_if.out_valid, 0);
        check("rst_dout", m_if.dout, 0);
        check("rst_ovf", m_if.ovf, 0);
        reset = 1'b0;
        step();
        check("idle_in_ready", m_if.in_ready, 1);

        send(-3, 7, 1'b0, 1'b0);
        in_valid = 1'b0;
        k = 0;
        while (!m_if.out_valid && k < 10) begin
            step();
            k++;
        end
        check("latency", k, NS + 1);
        check("lat_dout", m_if.dout, -21);
        check("lat_ovf", m_if.ovf, 0);
        drain();

        obs.delete();
        send(2, 3, 1'b1, 1'b1);
        send(4, 5, 1'b1, 1'b0);
        send(-1, 10, 1'b1, 1'b0);
        send(1, 1, 1'b1, 1'b1);
        drain();
        check4("mac", 6, 26, 16, 1);

        obs.delete();
        send(20, 30, 1'b0, 1'b0);
        send(-512, 1, 1'b0, 1'b0);
        drain();
        check("sat_n", obs.size(), 2);
        if (obs.size() == 2) begin
            check("sat_hi", obs[0].s, 511);
            check("sat_hi_ovf", obs[0].so, 1);
            check("wrap_hi", obs[0].w, -424);
            check("wrap_hi_ovf", obs[0].wo, 1);
            check("sat_min", obs[1].s, -512);
            check("sat_min_ovf", obs[1].so, 0);
            check("wrap_min", obs[1].w, -512);
            check("wrap_min_ovf", obs[1].wo, 0);
        end

        obs.delete();
        out_ready = 1'b0;
        send(3, 4, 1'b0, 1'b0);
        send(5, 6, 1'b0, 1'b0);
        send(-7, 8, 1'b0, 1'b0);
        send(9, -10, 1'b0, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_in_ready", m_if.in_ready, 0);
            check("bp_valid", m_if.out_valid, 1);
            check("bp_dout", m_if.dout, 12);
        end
        out_ready = 1'b1;
        drain();
        check4("bp", 12, 30, -56, -90);

        obs.delete();
        send(2, 3, 1'b1, 1'b1);
        send(4, 5, 1'b1, 1'b0);
        ce = 1'b0;
        din0 = -10'sd1;  din1 = 10'sd10;
        acc_clr = 1'b0;  in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ce_in_ready", m_if.in_ready, 0);
            check("ce_hold_valid", m_if.out_valid, 0);
            check("ce_hold_dout", m_if.dout, -90);
        end
        ce = 1'b1;
        send(-1, 10, 1'b1, 1'b0);
        send(1, 1, 1'b1, 1'b1);
        drain();
        check4("ce", 6, 26, 16, 1);

        out_ready = 1'b0;
        send(2, 3, 1'b1, 1'b1);
        send(4, 5, 1'b1, 1'b0);
        in_valid = 1'b0;
        step(3);
        check("pre_rst_valid", m_if.out_valid, 1);
        check("pre_rst_dout", m_if.dout, 6);
        #2;
        reset = 1'b1;
        expq.delete();
        macc = 0;
        #1;
        check("rst_async_valid", m_if.out_valid, 0);
        check("rst_async_dout", m_if.dout, 0);
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        obs.delete();
        send(5, 5, 1'b1, 1'b0);
        drain();
        check("post_rst_n", obs.size(), 1);
        if (obs.size() == 1)
            check("post_rst_mac", obs[0].m, 25);

        for (int i = 0; i < 400; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            din0      = W0'($urandom);
            din1      = W1'($urandom);
            mac_en    = 1'($urandom_range(0, 1));
            acc_clr   = $urandom_range(0, 7) == 0;
            out_ready = $urandom_range(0, 3) != 0;
            ce        = $urandom_range(0, 7) != 0;
            step();
        end
        ce = 1'b1;
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
